// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the banked APB slave memory.
package apb_slave_pkg;

  localparam int unsigned NUM_BANKS     = 3;
  localparam int unsigned BANK_W        = 2;
  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned CNT_W         = 16;

  localparam logic [CNT_W-1:0]  CNT_MAX    = 16'hFFFF;
  localparam logic [DATA_W-1:0] RD_INVALID = 32'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } phase_e;

  // Saturating counter step
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/apb_prot_checker.sv
// Sticky APB protocol-violation monitor; only instantiated when APB_PROT_CHECK_EN is defined.
module apb_prot_checker
  import apb_slave_pkg::*;
(
  input  logic                 hclk,
  input  logic                 hreset,
  input  phase_e               phase_prev,
  input  phase_e               phase_cur,
  input  logic [NUM_BANKS-1:0] setup_psel,
  input  logic [ADDR_W-1:0]    setup_paddr,
  input  logic                 setup_pwrite,
  input  logic [NUM_BANKS-1:0] psel,
  input  logic [ADDR_W-1:0]    paddr,
  input  logic                 pwrite,
  output logic                 prot_err
);

  logic viol_c;

  // Orphan/repeated ACCESS, SETUP->ACCESS control changes, multi-hot select
  always_comb begin
    viol_c = 1'b0;
    if (phase_cur == ACCESS) begin
      if (phase_prev != SETUP) begin
        viol_c = 1'b1;
      end else if ((psel != setup_psel) || (paddr != setup_paddr) ||
                   (pwrite != setup_pwrite)) begin
        viol_c = 1'b1;
      end
    end
    if ((psel != '0) && !$onehot(psel)) begin
      viol_c = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      prot_err <= 1'b0;
    end else if (viol_c) begin
      prot_err <= 1'b1;
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// Three-bank APB slave memory with transfer counters and sticky error flags.
// Optional protocol checker enabled by defining APB_PROT_CHECK_EN.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 pwrite,
  input  logic                 penable,
  input  logic [NUM_BANKS-1:0] psel,
  input  logic [ADDR_W-1:0]    paddr,
  input  logic [DATA_W-1:0]    pwdata,
  output logic [DATA_W-1:0]    prdata,
  output logic [CNT_W-1:0]     wr_count,
  output logic [CNT_W-1:0]     rd_count,
  output logic                 align_err,
  output logic                 prot_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0]    mem [NUM_BANKS][DEPTH];
  phase_e               phase_q;
  phase_e               phase_cur;
  logic [NUM_BANKS-1:0] setup_psel;
  logic [ADDR_W-1:0]    setup_paddr;
  logic                 setup_pwrite;
  logic [BANK_W-1:0]    bank_idx;
  logic [IDX_W-1:0]     word_idx;
  logic                 aligned;
  logic                 hit;

  // Phase decode from the live bus, plus bank/word decode
  always_comb begin
    phase_cur = IDLE;
    if (psel != '0) begin
      phase_cur = penable ? ACCESS : SETUP;
    end
    bank_idx = BANK_W'(0);
    case (psel)
      3'b010:  bank_idx = BANK_W'(1);
      3'b100:  bank_idx = BANK_W'(2);
      default: bank_idx = BANK_W'(0);
    endcase
    word_idx = paddr[IDX_W+1:2];
    aligned  = (paddr[1:0] == 2'b00);
    hit      = aligned && $onehot(psel);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      phase_q      <= IDLE;
      setup_psel   <= '0;
      setup_paddr  <= '0;
      setup_pwrite <= 1'b0;
      prdata       <= '0;
      wr_count     <= '0;
      rd_count     <= '0;
      align_err    <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem[b][w] <= '0;
        end
      end
    end else begin
      phase_q <= phase_cur;
      case (phase_cur)
        SETUP: begin
          setup_psel   <= psel;
          setup_paddr  <= paddr;
          setup_pwrite <= pwrite;
          if (!aligned) begin
            align_err <= 1'b1;
          end
          // Read data is fetched at setup so it is valid through ACCESS
          if (!pwrite) begin
            prdata <= hit ? mem[bank_idx][word_idx] : RD_INVALID;
          end
        end
        ACCESS: begin
          if (pwrite) begin
            if (hit) begin
              mem[bank_idx][word_idx] <= pwdata;
            end
            wr_count <= sat_inc(wr_count);
          end else begin
            rd_count <= sat_inc(rd_count);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef APB_PROT_CHECK_EN
  apb_prot_checker u_prot_checker (
    .hclk         (hclk),
    .hreset       (hreset),
    .phase_prev   (phase_q),
    .phase_cur    (phase_cur),
    .setup_psel   (setup_psel),
    .setup_paddr  (setup_paddr),
    .setup_pwrite (setup_pwrite),
    .psel         (psel),
    .paddr        (paddr),
    .pwrite       (pwrite),
    .prot_err     (prot_err)
  );
`else
  assign prot_err = 1'b0;
`endif

  // Upper address bits are ignored; setup state only feeds the optional checker
  logic unused_bits;
  assign unused_bits = ^{paddr[ADDR_W-1:IDX_W+2], setup_psel, setup_paddr,
                         setup_pwrite, phase_q};

endmodule
